fetch_unit: RTL

Instruction-fetch stage of the RISC-V pipeline: owns the program counter, drives the instruction-memory address, and presents `pc`, `inst` and the branch-prediction bit `guess` to the fetch/decode pipeline register. It predicts conditional branches with a table of 2-bit saturating counters and statically predicts JAL as taken. It consumes branch resolution from EX, and on a misprediction it redirects the PC and raises `flush` for the younger pipeline registers.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, predicts conditional branches with a
// table of 2-bit saturating counters, predicts JAL statically taken, and
// redirects on a direction misprediction reported by EX.
module fetch_unit #(
    parameter int          BHT_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        guess,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_guess,
    input  logic [31:0] ex_target,
    output logic        flush
);
    localparam int IDXW = $clog2(BHT_ENTRIES);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]     pc_q;
    logic [31:0]     pc_d;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] ex_idx;
    logic [1:0]      bht_rd [BHT_ENTRIES];
    logic [6:0]      opcode;
    logic [31:0]     imm_b;
    logic [31:0]     imm_j;
    logic [31:0]     pred_target;
    logic            guess_c;
    logic            mispredict;
    logic            bht_upd;

    assign idx     = pc_q[IDXW+1:2];
    assign ex_idx  = ex_pc[IDXW+1:2];
    assign bht_upd = ex_valid & ex_is_branch;

    // One saturating counter per entry; only the entry EX resolved moves.
    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] cnt_q;
            logic [1:0] cnt_d;

            // Step toward the resolved outcome, clamping at 00 and 11.
            always_comb begin
                cnt_d = cnt_q;
                if (bht_upd && (ex_idx == IDXW'(gi))) begin
                    if (ex_taken) begin
                        if (cnt_q != 2'b11) cnt_d = cnt_q + 2'd1;
                    end else begin
                        if (cnt_q != 2'b00) cnt_d = cnt_q - 2'd1;
                    end
                end
            end

            // Counters come out of reset weakly not-taken.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q <= 2'b01;
                else     cnt_q <= cnt_d;
            end

            assign bht_rd[gi] = cnt_q;
        end
    endgenerate

    // Predecode the fetched word: direction guess and exact taken target.
    always_comb begin
        opcode      = imem_rdata[6:0];
        imm_b       = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                       imem_rdata[11:8], 1'b0};
        imm_j       = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                       imem_rdata[30:21], 1'b0};
        guess_c     = 1'b0;
        pred_target = pc_q + imm_b;
        if (opcode == OP_BRANCH) begin
            guess_c     = bht_rd[idx][1];
            pred_target = pc_q + imm_b;
        end else if (opcode == OP_JAL) begin
            guess_c     = 1'b1;
            pred_target = pc_q + imm_j;
        end
    end

    // Only direction is verified in EX; fetch-computed targets are exact.
    assign mispredict = ex_valid & (ex_taken != ex_guess);

    // Next PC: EX redirect beats stall, stall beats the prediction.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (mispredict) begin
            pc_d = ex_taken ? ex_target : (ex_pc + 32'd4);
        end else if (stall) begin
            pc_d = pc_q;
        end else if (guess_c) begin
            pc_d = pred_target;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = imem_rdata;
    assign guess     = guess_c;
    assign flush     = mispredict;
endmodule
